// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encodings and default timing constants
//
// Purpose: state enum for the stopwatch controller, default debounce and
// tick-divider constants, and a small state-decode helper.
// Ports: none (package).
// Configuration macro: STOPWATCH_LAP_EN (consumed by stopwatch_ctrl).

package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_t;

  // 10 ms debounce and 100 Hz count tick at a 100 MHz clock.
  localparam int DEF_DB_CYCLES = 1000000;
  localparam int DEF_TICK_DIV  = 1000000;

  // The time counter advances in RUN and LAP alike; LAP only freezes the display.
  function automatic logic is_running(input state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - button synchronizer, debouncer and press detector
//
// Purpose: brings a raw asynchronous button into the clk domain, accepts a
// new level only after DB_CYCLES consecutive cycles of disagreement, and
// emits a registered one-cycle pulse on each accepted 0->1 transition.
// Ports:
//   clk   in  1  system clock
//   rst   in  1  synchronous active-high reset
//   raw   in  1  raw asynchronous button level, active-high
//   press out 1  one-cycle press event (registered)

module button_debounce #(
  parameter int DB_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  // Counter only needs to reach DB_CYCLES-1 before the level flips.
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      // Any cycle where the synchronized input agrees with the accepted
      // level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - two-button stopwatch control FSM with tick prescaler
//
// Purpose: start/stop and reset/lap control of a stopwatch time counter.
// Optional lap mode is compiled in with macro STOPWATCH_LAP_EN.
// Ports:
//   clk      in  1  system clock, single domain
//   rst      in  1  synchronous active-high reset
//   button0  in  1  raw start/stop button
//   button1  in  1  raw reset/lap button
//   tick     out 1  one-cycle count enable for the time counter
//   clr      out 1  one-cycle clear for the time counter
//   running  out 1  high in RUN or LAP
//   freeze   out 1  display hold, high only in LAP
//   state    out 2  current FSM state encoding

module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int TICK_DIV  = DEF_TICK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button0,
  input  logic       button1,
  output logic       tick,
  output logic       clr,
  output logic       running,
  output logic       freeze,
  output logic [1:0] state
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam bit DIV1 = (TICK_DIV == 1);

  logic          p0;
  logic          p1;
  state_t        cur;
  state_t        nxt;
  logic          do_clr;
  logic [PW-1:0] presc;
  logic          wrap;

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db0 (
    .clk   (clk),
    .rst   (rst),
    .raw   (button0),
    .press (p0)
  );

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db1 (
    .clk   (clk),
    .rst   (rst),
    .raw   (button1),
    .press (p1)
  );

  assign wrap = (presc == PW'(TICK_DIV - 1));

  // Simultaneous presses: b1 has priority in IDLE/PAUSE, b0 in RUN/LAP.
  always_comb begin
    nxt    = cur;
    do_clr = 1'b0;
    case (cur)
      ST_IDLE: begin
        if (p1)      do_clr = 1'b1;
        else if (p0) nxt = ST_RUN;
      end
      ST_RUN: begin
        if (p0) nxt = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (p1) nxt = ST_LAP;
`endif
      end
      ST_PAUSE: begin
        if (p1) begin
          nxt    = ST_IDLE;
          do_clr = 1'b1;
        end else if (p0) begin
          nxt = ST_RUN;
        end
      end
      ST_LAP: begin
        if (p0)      nxt = ST_PAUSE;
        else if (p1) nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= ST_IDLE;
      clr     <= 1'b0;
      tick    <= 1'b0;
      running <= 1'b0;
      presc   <= '0;
    end else begin
      cur     <= nxt;
      clr     <= do_clr;
      running <= is_running(nxt);
      if (do_clr) begin
        presc <= '0;
      end else if (is_running(cur)) begin
        presc <= wrap ? '0 : presc + PW'(1);
      end
      // Gating on the next state keeps tick low in the first cycle of PAUSE
      // even when the prescaler wraps on the leaving edge.
      tick <= is_running(nxt) && (DIV1 || (is_running(cur) && wrap));
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic freeze_q;

  always_ff @(posedge clk) begin
    if (rst) freeze_q <= 1'b0;
    else     freeze_q <= (nxt == ST_LAP);
  end

  assign freeze = freeze_q;
`else
  assign freeze = 1'b0;
`endif

  assign state = cur;

endmodule
